// File: rtl/am29_pkg.sv
// rtl/am29_pkg.sv - shared constants for the am2909 microprogram sequencer slice
package am29_pkg;

  // Address mux source codes on s[1:0]
  localparam logic [1:0] SRC_UPC = 2'b00;
  localparam logic [1:0] SRC_AR  = 2'b01;
  localparam logic [1:0] SRC_STK = 2'b10;
  localparam logic [1:0] SRC_D   = 2'b11;

  localparam int STACK_DEPTH = 4;
  localparam int SP_W        = $clog2(STACK_DEPTH);
  localparam int DEPTH_W     = $clog2(STACK_DEPTH + 1);

endpackage

// File: rtl/am2909_stack.sv
// rtl/am2909_stack.sv - 4-word circular return stack with pointer
// Optional depth/full/empty/ovf/unf tracking under AM2909_SEQ_STACK_FLAGS_EN.
module am2909_stack
  import am29_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clr_,
  input  logic             fe_,
  input  logic             pup,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top
`ifdef AM2909_SEQ_STACK_FLAGS_EN
  ,
  output logic             full,
  output logic             empty,
  output logic             ovf,
  output logic             unf
`endif
);

  localparam logic [SP_W-1:0] SP_ONE = SP_W'(1);

  logic [WIDTH-1:0] r_mem [STACK_DEPTH];
  logic [SP_W-1:0]  r_sp;
  logic [SP_W-1:0]  w_sp_inc;
  logic [SP_W-1:0]  w_sp_dec;

  assign w_sp_inc = r_sp + SP_ONE;
  assign w_sp_dec = r_sp - SP_ONE;

  // Push writes the slot above the pointer; a full stack simply wraps over the oldest word
  always_ff @(posedge clk or negedge clr_) begin
    if (!clr_) begin
      r_sp <= '0;
      for (int i = 0; i < STACK_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (!fe_) begin
      if (pup) begin
        r_sp           <= w_sp_inc;
        r_mem[w_sp_inc] <= push_data;
      end else begin
        r_sp <= w_sp_dec;
      end
    end
  end

  assign top = r_mem[r_sp];

`ifdef AM2909_SEQ_STACK_FLAGS_EN
  localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(STACK_DEPTH);
  localparam logic [DEPTH_W-1:0] DEPTH_ONE = DEPTH_W'(1);

  logic [DEPTH_W-1:0] r_depth;
  logic               r_ovf;
  logic               r_unf;

  // Depth saturates at both ends; the sticky flags record the attempted over/underflow
  always_ff @(posedge clk or negedge clr_) begin
    if (!clr_) begin
      r_depth <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else if (!fe_) begin
      if (pup) begin
        if (r_depth == DEPTH_MAX) begin
          r_ovf <= 1'b1;
        end else begin
          r_depth <= r_depth + DEPTH_ONE;
        end
      end else begin
        if (r_depth == '0) begin
          r_unf <= 1'b1;
        end else begin
          r_depth <= r_depth - DEPTH_ONE;
        end
      end
    end
  end

  assign full  = (r_depth == DEPTH_MAX);
  assign empty = (r_depth == '0);
  assign ovf   = r_ovf;
  assign unf   = r_unf;
`endif

endmodule

// File: rtl/am2909_seq.sv
// rtl/am2909_seq.sv - am2909-style microprogram sequencer slice (mux, incrementer, uPC, AR)
// Build with AM2909_SEQ_STACK_FLAGS_EN to expose stack full/empty/ovf/unf ports.
module am2909_seq
  import am29_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clr_,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] r,
  input  logic [WIDTH-1:0] orin,
  input  logic [1:0]       s,
  input  logic             re_,
  input  logic             fe_,
  input  logic             pup,
  input  logic             zero_,
  input  logic             oe_,
  input  logic             cn,
  output wire  [WIDTH-1:0] y,
  output logic             cn4
`ifdef AM2909_SEQ_STACK_FLAGS_EN
  ,
  output logic             full,
  output logic             empty,
  output logic             ovf,
  output logic             unf
`endif
);

  logic [WIDTH-1:0] r_upc;
  logic [WIDTH-1:0] r_ar;
  logic [WIDTH-1:0] w_top;
  logic [WIDTH-1:0] w_mux;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_sum;

  always_comb begin
    w_mux = d;
    case (s)
      SRC_UPC: w_mux = r_upc;
      SRC_AR:  w_mux = r_ar;
      SRC_STK: w_mux = w_top;
      SRC_D:   w_mux = d;
      default: w_mux = d;
    endcase
  end

  assign w_a = zero_ ? (w_mux | orin) : '0;

  // Carry-out is taken from the internal address, so it is valid even while y floats
  assign {cn4, w_sum} = {1'b0, w_a} + (WIDTH + 1)'(cn);

  assign y = oe_ ? {WIDTH{1'bz}} : w_a;

  always_ff @(posedge clk or negedge clr_) begin
    if (!clr_) begin
      r_upc <= '0;
      r_ar  <= '0;
    end else begin
      r_upc <= w_sum;
      if (!re_) begin
        r_ar <= r;
      end
    end
  end

  am2909_stack #(
    .WIDTH(WIDTH)
  ) u_stack (
    .clk      (clk),
    .clr_     (clr_),
    .fe_      (fe_),
    .pup      (pup),
    .push_data(r_upc),
    .top      (w_top)
`ifdef AM2909_SEQ_STACK_FLAGS_EN
    ,
    .full     (full),
    .empty    (empty),
    .ovf      (ovf),
    .unf      (unf)
`endif
  );

endmodule

// File: tb/tb_am2909_seq.sv
// tb/tb_am2909_seq.sv - self-checking bench for am2909_seq against a behavioural model
module tb_am2909_seq;

  logic       clk;
  logic       clr_;
  logic [3:0] d;
  logic [3:0] r;
  logic [3:0] orin;
  logic [1:0] s;
  logic       re_;
  logic       fe_;
  logic       pup;
  logic       zero_;
  logic       oe_;
  logic       cn;
  wire  [3:0] y_w;
  logic       cn4;
`ifdef AM2909_SEQ_STACK_FLAGS_EN
  logic       full;
  logic       empty;
  logic       ovf;
  logic       unf;
`endif

  int n_total;
  int n_bad;

  // Weak keeper pattern: visible on y only when the DUT releases the bus
  assign y_w = oe_ ? 4'b1010 : 4'bzzzz;

  am2909_seq #(
    .WIDTH(4)
  ) dut (
    .clk  (clk),
    .clr_ (clr_),
    .d    (d),
    .r    (r),
    .orin (orin),
    .s    (s),
    .re_  (re_),
    .fe_  (fe_),
    .pup  (pup),
    .zero_(zero_),
    .oe_  (oe_),
    .cn   (cn),
    .y    (y_w),
    .cn4  (cn4)
`ifdef AM2909_SEQ_STACK_FLAGS_EN
    ,
    .full (full),
    .empty(empty),
    .ovf  (ovf),
    .unf  (unf)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

  // Behavioural reference: integer state, circular stack as an array indexed mod 4
  int m_upc;
  int m_ar;
  int m_sp;
  int m_depth;
  int m_stk[4];
  bit m_ovf;
  bit m_unf;

  function automatic void m_reset();
    m_upc = 0; m_ar = 0; m_sp = 0; m_depth = 0;
    for (int i = 0; i < 4; i++) m_stk[i] = 0;
    m_ovf = 0; m_unf = 0;
  endfunction

  function automatic int m_a();
    int mux;
    case (s)
      2'd0: mux = m_upc;
      2'd1: mux = m_ar;
      2'd2: mux = m_stk[m_sp];
      default: mux = int'(d);
    endcase
    return zero_ ? (mux | int'(orin)) : 0;
  endfunction

  function automatic int m_y();
    return oe_ ? 10 : m_a();
  endfunction

  function automatic bit m_cn4();
    return (m_a() + int'(cn)) >= 16;
  endfunction

  function automatic void m_clock();
    int a_v;
    int old_upc;
    old_upc = m_upc;
    a_v = m_a();
    m_upc = (a_v + int'(cn)) % 16;
    if (!re_) m_ar = int'(r);
    if (!fe_) begin
      if (pup) begin
        m_sp = (m_sp + 1) % 4;
        m_stk[m_sp] = old_upc;
        if (m_depth == 4) m_ovf = 1; else m_depth++;
      end else begin
        m_sp = (m_sp + 3) % 4;
        if (m_depth == 0) m_unf = 1; else m_depth--;
      end
    end
  endfunction

  task automatic tick();
    m_clock();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    d = 4'h0; r = 4'h0; orin = 4'h0; s = 2'b00;
    re_ = 1'b1; fe_ = 1'b1; pup = 1'b0; zero_ = 1'b1; oe_ = 1'b0; cn = 1'b0;
  endtask

  task automatic do_reset();
    set_idle();
    @(negedge clk);
    clr_ = 1'b0;
    m_reset();
    #2;
    clr_ = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_total++;
    if (y_w !== 4'h0) begin n_bad++; $display("FAIL reset_y got=%h want=0", y_w); end
    cn = 1'b1; #1;
    n_total++;
    if (cn4 !== 1'b0) begin n_bad++; $display("FAIL reset_cn4 got=%b want=0", cn4); end
    s = 2'b01; #1;
    n_total++;
    if (y_w !== 4'h0) begin n_bad++; $display("FAIL reset_ar got=%h want=0", y_w); end
    s = 2'b10; #1;
    n_total++;
    if (y_w !== 4'h0) begin n_bad++; $display("FAIL reset_top got=%h want=0", y_w); end
`ifdef AM2909_SEQ_STACK_FLAGS_EN
    n_total++;
    if ({full, empty, ovf, unf} !== 4'b0100) begin
      n_bad++; $display("FAIL reset_flags got=%b want=0100", {full, empty, ovf, unf});
    end
`endif
  endtask

  task automatic test_increment_wrap();
    do_reset();
    cn = 1'b1;
    #1;
    for (int i = 0; i < 17; i++) begin
      n_total++;
      if (y_w !== 4'(i % 16)) begin
        n_bad++; $display("FAIL wrap_y step=%0d got=%h want=%h", i, y_w, 4'(i % 16));
      end
      n_total++;
      if (cn4 !== ((i % 16) == 15)) begin
        n_bad++; $display("FAIL wrap_cn4 step=%0d got=%b want=%b", i, cn4, (i % 16) == 15);
      end
      if (i < 16) tick();
    end
  endtask

  task automatic test_ar_or_zero();
    do_reset();
    r = 4'hA; re_ = 1'b0;
    tick();
    re_ = 1'b1; r = 4'h3; s = 2'b01; #1;
    n_total++;
    if (y_w !== 4'hA) begin n_bad++; $display("FAIL ar_load got=%h want=a", y_w); end
    orin = 4'h5; cn = 1'b1; #1;
    n_total++;
    if (y_w !== 4'hF) begin n_bad++; $display("FAIL ar_or got=%h want=f", y_w); end
    n_total++;
    if (cn4 !== 1'b1) begin n_bad++; $display("FAIL ar_or_cn4 got=%b want=1", cn4); end
    zero_ = 1'b0; #1;
    n_total++;
    if (y_w !== 4'h0) begin n_bad++; $display("FAIL ar_zero got=%h want=0", y_w); end
    n_total++;
    if (cn4 !== 1'b0) begin n_bad++; $display("FAIL ar_zero_cn4 got=%b want=0", cn4); end
    zero_ = 1'b1; orin = 4'h0; re_ = 1'b1;
    tick();
    n_total++;
    if (y_w !== 4'hA) begin n_bad++; $display("FAIL ar_hold got=%h want=a", y_w); end
  endtask

  task automatic test_stack_sequence();
    int exp_top[4];
    exp_top[0] = 6; exp_top[1] = 5; exp_top[2] = 4; exp_top[3] = 7;
    do_reset();
    cn = 1'b1;
    repeat (3) tick();
    n_total++;
    if (y_w !== 4'h3) begin n_bad++; $display("FAIL stk_upc got=%h want=3", y_w); end
    fe_ = 1'b0; pup = 1'b1;
    tick();
    fe_ = 1'b1; s = 2'b10; #1;
    n_total++;
    if (y_w !== 4'h3) begin n_bad++; $display("FAIL stk_push1 got=%h want=3", y_w); end
    s = 2'b00; fe_ = 1'b0; pup = 1'b1;
    repeat (4) tick();
    fe_ = 1'b1; s = 2'b10; #1;
    n_total++;
    if (y_w !== 4'h7) begin n_bad++; $display("FAIL stk_push5 got=%h want=7", y_w); end
`ifdef AM2909_SEQ_STACK_FLAGS_EN
    n_total++;
    if ({ovf, full} !== 2'b11) begin n_bad++; $display("FAIL stk_ovf got=%b want=11", {ovf, full}); end
`endif
    for (int i = 0; i < 4; i++) begin
      s = 2'b00; fe_ = 1'b0; pup = 1'b0;
      tick();
      fe_ = 1'b1; s = 2'b10; #1;
      n_total++;
      if (y_w !== 4'(exp_top[i])) begin
        n_bad++; $display("FAIL stk_pop idx=%0d got=%h want=%h", i, y_w, 4'(exp_top[i]));
      end
    end
`ifdef AM2909_SEQ_STACK_FLAGS_EN
    n_total++;
    if ({unf, empty} !== 2'b01) begin n_bad++; $display("FAIL stk_pre_unf got=%b want=01", {unf, empty}); end
    s = 2'b00; fe_ = 1'b0; pup = 1'b0;
    tick();
    fe_ = 1'b1;
    n_total++;
    if ({unf, empty, ovf} !== 3'b111) begin n_bad++; $display("FAIL stk_unf got=%b want=111", {unf, empty, ovf}); end
`endif
  endtask

  task automatic test_tristate();
    do_reset();
    oe_ = 1'b1; s = 2'b11; d = 4'hF; cn = 1'b1; #1;
    n_total++;
    if (y_w !== 4'b1010) begin n_bad++; $display("FAIL tri_float got=%b want=released(1010)", y_w); end
    n_total++;
    if (cn4 !== 1'b1) begin n_bad++; $display("FAIL tri_cn4 got=%b want=1", cn4); end
    tick();
    s = 2'b00; oe_ = 1'b0; #1;
    n_total++;
    if (y_w !== 4'h0) begin n_bad++; $display("FAIL tri_wrap got=%h want=0", y_w); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    cn = 1'b1; r = 4'hA; re_ = 1'b0;
    tick();
    re_ = 1'b1; fe_ = 1'b0; pup = 1'b1;
    repeat (2) tick();
    fe_ = 1'b1; #1;
    n_total++;
    if (y_w !== 4'h3) begin n_bad++; $display("FAIL mid_before got=%h want=3", y_w); end
    clr_ = 1'b0; m_reset(); #1;
    n_total++;
    if (y_w !== 4'h0) begin n_bad++; $display("FAIL mid_async got=%h want=0", y_w); end
    #1;
    clr_ = 1'b1;
    s = 2'b10; #1;
    n_total++;
    if (y_w !== 4'h0) begin n_bad++; $display("FAIL mid_top got=%h want=0", y_w); end
    s = 2'b01; #1;
    n_total++;
    if (y_w !== 4'h0) begin n_bad++; $display("FAIL mid_ar got=%h want=0", y_w); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      d     = 4'($urandom_range(0, 15));
      r     = 4'($urandom_range(0, 15));
      orin  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
      s     = 2'($urandom_range(0, 3));
      re_   = 1'($urandom_range(0, 1));
      fe_   = 1'($urandom_range(0, 1));
      pup   = 1'($urandom_range(0, 1));
      zero_ = ($urandom_range(0, 7) != 0);
      oe_   = ($urandom_range(0, 5) == 0);
      cn    = 1'($urandom_range(0, 1));
      #1;
      n_total++;
      if (y_w !== 4'(m_y())) begin
        n_bad++; $display("FAIL rand_y iter=%0d got=%h want=%h", i, y_w, 4'(m_y()));
      end
      n_total++;
      if (cn4 !== m_cn4()) begin
        n_bad++; $display("FAIL rand_cn4 iter=%0d got=%b want=%b", i, cn4, m_cn4());
      end
`ifdef AM2909_SEQ_STACK_FLAGS_EN
      n_total++;
      if ({full, empty, ovf, unf} !== {m_depth == 4, m_depth == 0, m_ovf, m_unf}) begin
        n_bad++; $display("FAIL rand_flags iter=%0d got=%b want=%b", i,
                          {full, empty, ovf, unf}, {m_depth == 4, m_depth == 0, m_ovf, m_unf});
      end
`endif
      tick();
    end
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    clr_    = 1'b1;
    set_idle();
    m_reset();
    test_reset();
    test_increment_wrap();
    test_ar_or_zero();
    test_stack_sequence();
    test_tristate();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/am2909_seq.md
AM2909_SEQ -- requirements
Module: am2909_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the microprogram address slice width in bits.
REQ-002 SHALL have ports:
  clk  in  1  rising-edge clock
  clr_  in  1  asynchronous active-low reset
  d  in  WIDTH  direct address input
  r  in  WIDTH  address-register input
  orin  in  WIDTH  OR-mask onto selected address
  s  in  2  source select
  re_  in  1  address-register load enable, active low
  fe_  in  1  stack file enable, active low
  pup  in  1  push (1) / pop (0) when fe_ low
  zero_  in  1  force address zero, active low
  oe_  in  1  output enable, active low
  cn  in  1  incrementer carry-in
  y  out  WIDTH  microprogram address, tri-state; feeds the downstream pipeline register
  cn4  out  1  incrementer carry-out
REQ-003 SHALL use one clock; reset is asynchronous and active-low.

Function
REQ-004 SHALL select mux source combinationally: s=00 uPC, s=01 AR, s=10 stack top, s=11 d.
REQ-005 SHALL form internal address a = (mux | orin) when zero_=1, and a = 0 when zero_=0.
REQ-006 SHALL drive y = a when oe_=0 and high-impedance when oe_=1.
REQ-007 SHALL compute {cn4, sum} = a + cn (WIDTH+1 bits), independent of oe_; all-ones plus cn=1 wraps sum to 0 with cn4=1.
REQ-008 SHALL load uPC with sum on every rising clk edge.
REQ-009 SHALL load AR from r on rising clk when re_=0, and hold it otherwise.
REQ-010 SHALL implement a 4-word stack with a 2-bit pointer sp; top = stack[sp].
REQ-011 SHALL hold the stack when fe_=1.
REQ-012 SHALL push when fe_=0 and pup=1: sp <= sp+1 (mod 4), and stack[sp+1] <= uPC value from before the edge.
REQ-013 SHALL pop when fe_=0 and pup=0: sp <= sp-1 (mod 4); contents are unchanged.
REQ-014 SHALL use pre-edge values in all same-cycle events: y and sum use the pre-edge top; a push stores the pre-edge uPC.
REQ-015 SHALL overwrite the oldest entry on a push when the stack holds 4 words (circular, no error without REQ-019).
REQ-016 SHALL have zero latency from inputs to y/cn4; all state changes occur only at the clk edge.

Reset
REQ-017 SHALL, while clr_=0, force uPC=0, AR=0, sp=0, all stack words=0, depth=0, and ovf=unf=0, independent of clk.
REQ-018 SHALL, after reset with s=00, zero_=1, oe_=0 and orin=0, output y=0; cn4 equals cn only when WIDTH is 0 (i.e. cn4=0).

Configuration
REQ-019 Macro AM2909_SEQ_STACK_FLAGS_EN, when defined, SHALL add these behaviours:
  - a 3-bit depth counter (0..4) and output ports full (depth=4) and empty (depth=0);
  - sticky ovf, set on a push at depth 4, with depth saturating at 4;
  - sticky unf, set on a pop at depth 0, with depth staying at 0;
  - ovf and unf clear only on reset.
REQ-020 Without the macro, these ports and the depth counter SHALL be absent, and stack behaviour SHALL be identical otherwise.

Structure
REQ-021 SHALL place these items in shared package am29_pkg:
  - source-select constants SRC_UPC, SRC_AR, SRC_STK, SRC_D;
  - constant STACK_DEPTH=4.
REQ-022 SHALL implement the stack file and its pointer (and optional flags) as sub-module am2909_stack; the mux, incrementer, uPC and AR SHALL reside in am2909_seq.

Verification
REQ-023 Reset mid-operation: load AR=0xA, push twice, then assert clr_=0 between edges -> y=0 immediately (s=00); after release, s=10 gives y=0 and s=01 gives y=0.
REQ-024 Increment wrap: WIDTH=4, s=00, cn=1, 17 clocks from reset -> y steps 0..15 then 0; cn4=1 only while y=15.
REQ-025 AR/OR/zero: r=0xA, re_=0, one clk, s=01 -> y=0xA; orin=0x5 -> y=0xF; zero_=0 -> y=0x0.
REQ-026 Stack push/pop sequence:
  - with uPC=3, fe_=0, pup=1, one clk -> s=10 gives y=3;
  - four more pushes of uPC=4,5,6,7 -> top=7, and with the macro ovf=1 and full=1;
  - four pops -> tops 6,5,4,7 (circular);
  - with the macro, one further pop at depth 0 sets unf=1.
REQ-027 Tri-state: oe_=1, s=11, d=0xF, cn=1 -> y=Z, cn4=1; one clk then s=00, oe_=0 -> y=0x0.
